// File: rtl/riscv_pc_pkg.sv
// Shared types and constants for the fetch/next-PC sequencer.
package riscv_pc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EXEC,
        ST_TRAP
    } pc_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select (JALR > JAL > taken branch > PC+4) with misalign detect.
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        branch,
    input  logic        jal,
    input  logic        jalr,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] pc_imm;
    logic [31:0] pc_seq;

    always_comb begin
        pc_imm = pc + imm;
        pc_seq = pc + 32'd4;
        if (jalr) begin
            next_pc = {alu_result[31:1], 1'b0};
        end else if (jal) begin
            next_pc = pc_imm;
        end else if (branch && alu_result[0]) begin
            next_pc = pc_imm;
        end else begin
            next_pc = pc_seq;
        end
        misalign = |next_pc[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch handshake, one-cycle execute hold and next-PC update with sticky traps.
// Optional perf counters: define PC_PERF_COUNTERS_EN.
module pc_sequencer
    import riscv_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        Fetch_Req_o,
    output logic [31:0] Fetch_Addr_o,
    input  logic        Fetch_Gnt_i,
    input  logic        Fetch_Rvalid_i,
    input  logic [31:0] Fetch_Data_i,
    output logic [31:0] Instr_o,
    output logic        Instr_Valid_o,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus4_o,
    input  logic        Branch_i,
    input  logic        Jal_i,
    input  logic        Jalr_i,
    input  logic [31:0] Imm_i,
    input  logic [31:0] ALU_Result_i,
    output logic        Trap_o,
    output logic [1:0]  Trap_Cause_o
`ifdef PC_PERF_COUNTERS_EN
    ,
    output logic [31:0] Retired_Count_o,
    output logic [31:0] Taken_Count_o
`endif
);

    pc_state_t   state, next_state;
    logic [7:0]  timeout_cnt;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        misalign;
    logic        wait_expired;

    next_pc_calc u_next_pc_calc (
        .pc         (pc_q),
        .imm        (Imm_i),
        .alu_result (ALU_Result_i),
        .branch     (Branch_i),
        .jal        (Jal_i),
        .jalr       (Jalr_i),
        .next_pc    (next_pc),
        .misalign   (misalign)
    );

    // The WAIT cycle that would bring the count to FETCH_TIMEOUT is the last one.
    assign wait_expired = (timeout_cnt == 8'(FETCH_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: next_state = ST_REQ;
            ST_REQ: begin
                if (Fetch_Gnt_i) begin
                    next_state = Fetch_Rvalid_i ? ST_EXEC : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Fetch_Rvalid_i) begin
                    next_state = ST_EXEC;
                end else if (wait_expired) begin
                    next_state = ST_TRAP;
                end
            end
            ST_EXEC: next_state = misalign ? ST_TRAP : ST_REQ;
            ST_TRAP: next_state = ST_TRAP;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        Fetch_Req_o   = (state == ST_REQ);
        Instr_Valid_o = (state == ST_EXEC);
        PC_o          = pc_q;
        Fetch_Addr_o  = pc_q;
        PC_Plus4_o    = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            Instr_o      <= '0;
            Trap_o       <= 1'b0;
            Trap_Cause_o <= CAUSE_NONE;
            timeout_cnt  <= '0;
        end else begin
            timeout_cnt <= (state == ST_WAIT && next_state == ST_WAIT) ? timeout_cnt + 8'd1 : '0;
            case (state)
                ST_REQ: begin
                    if (Fetch_Gnt_i && Fetch_Rvalid_i) begin
                        Instr_o <= Fetch_Data_i;
                    end
                end
                ST_WAIT: begin
                    if (Fetch_Rvalid_i) begin
                        Instr_o <= Fetch_Data_i;
                    end else if (wait_expired) begin
                        Trap_o       <= 1'b1;
                        Trap_Cause_o <= CAUSE_TIMEOUT;
                    end
                end
                ST_EXEC: begin
                    if (misalign) begin
                        Trap_o       <= 1'b1;
                        Trap_Cause_o <= CAUSE_MISALIGN;
                    end else begin
                        pc_q <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PC_PERF_COUNTERS_EN
    logic redirect;
    assign redirect = Jalr_i | Jal_i | (Branch_i & ALU_Result_i[0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            Retired_Count_o <= '0;
            Taken_Count_o   <= '0;
        end else if (state == ST_EXEC && !misalign) begin
            Retired_Count_o <= Retired_Count_o + 32'd1;
            if (redirect) begin
                Taken_Count_o <= Taken_Count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed fetch/execute vectors, monitor pops on handshakes.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          BUDGET = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        Fetch_Req_o;
    logic [31:0] Fetch_Addr_o;
    logic        Fetch_Gnt_i;
    logic        Fetch_Rvalid_i;
    logic [31:0] Fetch_Data_i;
    logic [31:0] Instr_o;
    logic        Instr_Valid_o;
    logic [31:0] PC_o;
    logic [31:0] PC_Plus4_o;
    logic        Branch_i;
    logic        Jal_i;
    logic        Jalr_i;
    logic [31:0] Imm_i;
    logic [31:0] ALU_Result_i;
    logic        Trap_o;
    logic [1:0]  Trap_Cause_o;
`ifdef PC_PERF_COUNTERS_EN
    logic [31:0] Retired_Count_o;
    logic [31:0] Taken_Count_o;
`endif

    pc_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .Fetch_Req_o    (Fetch_Req_o),
        .Fetch_Addr_o   (Fetch_Addr_o),
        .Fetch_Gnt_i    (Fetch_Gnt_i),
        .Fetch_Rvalid_i (Fetch_Rvalid_i),
        .Fetch_Data_i   (Fetch_Data_i),
        .Instr_o        (Instr_o),
        .Instr_Valid_o  (Instr_Valid_o),
        .PC_o           (PC_o),
        .PC_Plus4_o     (PC_Plus4_o),
        .Branch_i       (Branch_i),
        .Jal_i          (Jal_i),
        .Jalr_i         (Jalr_i),
        .Imm_i          (Imm_i),
        .ALU_Result_i   (ALU_Result_i),
        .Trap_o         (Trap_o),
        .Trap_Cause_o   (Trap_Cause_o)
`ifdef PC_PERF_COUNTERS_EN
        ,
        .Retired_Count_o(Retired_Count_o),
        .Taken_Count_o  (Taken_Count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exec_t;

    exec_t       exp_exec_q[$];
    logic [31:0] exp_addr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model_retired = 0;
    int          model_taken = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: compare every execute cycle and every accepted fetch against the queues.
    always @(negedge clk) begin
        exec_t       e;
        logic [31:0] a;
        if (reset === 1'b1 && Instr_Valid_o === 1'b1) begin
            if (exp_exec_q.size() == 0) begin
                fail_now("unexpected_exec");
            end else begin
                e = exp_exec_q.pop_front();
                check32("exec_pc", PC_o, e.pc);
                check32("exec_instr", Instr_o, e.instr);
                check32("exec_pc_plus4", PC_Plus4_o, e.pc + 32'd4);
            end
        end
        if (reset === 1'b1 && Fetch_Req_o === 1'b1 && Fetch_Gnt_i === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                fail_now("unexpected_fetch");
            end else begin
                a = exp_addr_q.pop_front();
                check32("fetch_addr", Fetch_Addr_o, a);
            end
        end
    end

    task automatic clear_ctrl();
        Branch_i     = 1'b0;
        Jal_i        = 1'b0;
        Jalr_i       = 1'b0;
        Imm_i        = '0;
        ALU_Result_i = '0;
    endtask

    task automatic do_reset();
`ifdef PC_PERF_COUNTERS_EN
        check32("retired_count", Retired_Count_o, 32'(model_retired));
        check32("taken_count", Taken_Count_o, 32'(model_taken));
`endif
        reset          = 1'b0;
        Fetch_Gnt_i    = 1'b0;
        Fetch_Rvalid_i = 1'b0;
        Fetch_Data_i   = '0;
        clear_ctrl();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_retired = 0;
        model_taken   = 0;
        check32("rst_pc", PC_o, RST_PC);
        check32("rst_addr", Fetch_Addr_o, RST_PC);
        check32("rst_instr", Instr_o, 32'h0);
        check32("rst_valid", {31'b0, Instr_Valid_o}, 32'h0);
        check32("rst_req", {31'b0, Fetch_Req_o}, 32'h0);
        check32("rst_trap", {31'b0, Trap_o}, 32'h0);
        check32("rst_cause", {30'b0, Trap_Cause_o}, 32'h0);
`ifdef PC_PERF_COUNTERS_EN
        check32("rst_retired", Retired_Count_o, 32'h0);
        check32("rst_taken", Taken_Count_o, 32'h0);
`endif
    endtask

    // rv_cycle: 0 = data with the grant, k = data in WAIT cycle k, -1 = never.
    task automatic serve_fetch(input logic [31:0] addr, input logic [31:0] data,
                               input int rv_cycle, input logic expect_exec);
        bit seen = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (Fetch_Req_o === 1'b1) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            fail_now("fetch_req_wait");
            return;
        end
        exp_addr_q.push_back(addr);
        if (expect_exec) exp_exec_q.push_back({addr, data});
        Fetch_Gnt_i = 1'b1;
        if (rv_cycle == 0) begin
            Fetch_Rvalid_i = 1'b1;
            Fetch_Data_i   = data;
        end
        @(posedge clk);
        #1;
        Fetch_Gnt_i    = 1'b0;
        Fetch_Rvalid_i = 1'b0;
        if (rv_cycle > 0) begin
            repeat (rv_cycle - 1) begin
                @(posedge clk);
                #1;
            end
            Fetch_Rvalid_i = 1'b1;
            Fetch_Data_i   = data;
            @(posedge clk);
            #1;
            Fetch_Rvalid_i = 1'b0;
        end
    endtask

    task automatic exec(input logic br, input logic jal, input logic jalr,
                        input logic [31:0] imm, input logic [31:0] alu,
                        input logic taken, input logic traps);
        bit seen = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (Instr_Valid_o === 1'b1) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            fail_now("exec_wait");
            return;
        end
        Branch_i     = br;
        Jal_i        = jal;
        Jalr_i       = jalr;
        Imm_i        = imm;
        ALU_Result_i = alu;
        @(posedge clk);
        #1;
        clear_ctrl();
        if (!traps) begin
            model_retired++;
            if (taken) model_taken++;
        end
    endtask

    initial begin
        int req_seen;
        reset = 1'b0;
        Fetch_Gnt_i = 1'b0;
        Fetch_Rvalid_i = 1'b0;
        Fetch_Data_i = '0;
        clear_ctrl();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic fetch, then branch/jump/JALR selection and the 2^32 wrap.
        serve_fetch(32'h0040_0000, 32'h0000_0013, 1, 1);
        exec(0, 0, 0, 32'h0, 32'h0, 0, 0);
        serve_fetch(32'h0040_0004, 32'h00C0_006F, 1, 1);
        exec(0, 1, 0, 32'h0000_000C, 32'h0, 1, 0);
        serve_fetch(32'h0040_0010, 32'hFE00_0CE3, 0, 1);
        exec(1, 0, 0, 32'hFFFF_FFF8, 32'h1, 1, 0);
        serve_fetch(32'h0040_0008, 32'h0080_006F, 2, 1);
        exec(0, 1, 0, 32'h0000_0008, 32'h0, 1, 0);
        serve_fetch(32'h0040_0010, 32'hFE00_0CE3, 0, 1);
        exec(1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 0);
        serve_fetch(32'h0040_0014, 32'h0000_80E7, 1, 1);
        exec(0, 1, 1, 32'h0000_0040, 32'h0040_0101, 1, 0);
        serve_fetch(32'h0040_0100, 32'h0000_00E7, 3, 1);
        exec(0, 0, 1, 32'h0, 32'hFFFF_FFFD, 1, 0);
        serve_fetch(32'hFFFF_FFFC, 32'h0000_0013, 0, 1);
        exec(0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Misaligned JAL target at PC 0 traps and halts fetching.
        serve_fetch(32'h0000_0000, 32'h0060_006F, 1, 1);
        exec(0, 1, 0, 32'h0000_0006, 32'h0, 1, 1);
        check32("misalign_trap", {31'b0, Trap_o}, 32'h1);
        check32("misalign_cause", {30'b0, Trap_Cause_o}, 32'h1);
        check32("misalign_pc", PC_o, 32'h0000_0000);
        req_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (Fetch_Req_o !== 1'b0 || Instr_Valid_o !== 1'b0) req_seen++;
            @(posedge clk);
            #1;
        end
        check32("trap_no_req", 32'(req_seen), 32'h0);
        do_reset();

        // Fetch timeout: 16 WAIT cycles without Rvalid.
        serve_fetch(RST_PC, 32'h0, -1, 0);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        check32("pre_timeout_trap", {31'b0, Trap_o}, 32'h0);
        @(posedge clk);
        #1;
        check32("timeout_trap", {31'b0, Trap_o}, 32'h1);
        check32("timeout_cause", {30'b0, Trap_Cause_o}, 32'h2);
        check32("timeout_pc", PC_o, RST_PC);
        check32("timeout_req", {31'b0, Fetch_Req_o}, 32'h0);
        do_reset();

        // Rvalid in the 15th WAIT cycle completes normally.
        serve_fetch(RST_PC, 32'h00A0_0093, 15, 1);
        exec(0, 0, 0, 32'h0, 32'h0, 0, 0);
        check32("late_ok_trap", {31'b0, Trap_o}, 32'h0);

        // Reset in WAIT aborts the fetch; a stray Rvalid afterwards is ignored.
        serve_fetch(32'h0040_0004, 32'h0, -1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check32("wait_rst_pc", PC_o, RST_PC);
        check32("wait_rst_req", {31'b0, Fetch_Req_o}, 32'h0);
        Fetch_Rvalid_i = 1'b1;
        Fetch_Data_i   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        Fetch_Rvalid_i = 1'b0;
        check32("stray_rvalid_instr", Instr_o, 32'h0);
        check32("stray_rvalid_valid", {31'b0, Instr_Valid_o}, 32'h0);
        model_retired = 0;
        model_taken   = 0;
        serve_fetch(RST_PC, 32'h0000_0033, 1, 1);
        exec(0, 0, 0, 32'h0, 32'h0, 0, 0);
        serve_fetch(32'h0040_0004, 32'h0000_0013, 0, 1);
        exec(1, 0, 0, 32'h0000_0100, 32'h0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
`ifdef PC_PERF_COUNTERS_EN
        check32("final_retired", Retired_Count_o, 32'(model_retired));
        check32("final_taken", Taken_Count_o, 32'(model_taken));
`endif
        check32("exec_queue_empty", 32'(exp_exec_q.size()), 32'h0);
        check32("addr_queue_empty", 32'(exp_addr_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
